freq_div_ctrl: RTL and testbench
================================

Name: freq_div_ctrl

Overview:
Sequencing controller for the programmable clock-divider datapath; replaces the free-running ripple divider wherever software needs a configured, startable and stoppable divided clock.
- Accepts a divisor and burst length over a valid/ready handshake.
- On start, produces a divided square wave plus a one-cycle tick per output period.
- Runs either continuously or for a fixed number of periods, then signals done.
- Sits between the control register block and every consumer of divided clocks or clock enables.

Parameters:
CNT_W, 8, width of divisor and period counter
BURST_W, 8, width of burst-length field and period tally

Ports:
clk  input  1  system clock, all state on rising edge
init  input  1  asynchronous active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted
cfg_div  input  CNT_W  divisor D (output period in clk cycles)
cfg_burst  input  BURST_W  number of periods to run, 0 = continuous
start  input  1  begin generation (level sampled per cycle)
stop  input  1  abort generation
sq_out  output  1  divided square wave
tick  output  1  one-cycle pulse on last cycle of each period
busy  output  1  high while generating
done  output  1  one-cycle pulse after final burst period

Behaviour:
- Reset
  - Single clock clk; reset init is asynchronous, active-high, and may assert at any time, including mid-run.
  - On init: state=IDLE; div_reg=2; burst_reg=0; counters=0; sq_out=0; tick=0; busy=0; done=0.
  - cfg_ready is decoded from state, so it reads 1 in IDLE.
- States: IDLE, ARMED, RUN.
- IDLE
  - cfg_ready=1.
  - A handshake (cfg_valid & cfg_ready) latches div_reg=max(cfg_div,2) and burst_reg=cfg_burst, then moves to ARMED.
  - start is ignored.
- ARMED
  - cfg_ready=1; a new handshake overwrites the registers and the state stays ARMED.
  - start & !stop -> RUN, period index k=0, tally=0.
  - start & stop together: stop wins, stay ARMED.
- RUN
  - busy=1; cfg_ready=0.
  - Period index k advances 0..D-1 once per cycle and wraps to 0.
  - First RUN cycle is k=0.
  - sq_out=1 for k < floor(D/2), else 0; D=3 gives high 1 cycle, low 2 cycles.
  - tick=1 exactly when k=D-1; tally increments on each tick.
  - All outputs are registered and valid in the cycle that k names; no combinational path from inputs to outputs.
- Burst end
  - burst_reg!=0 and tick occurs with tally+1==burst_reg: next cycle state=ARMED, done=1 for one cycle, busy=0, sq_out=0.
  - Configuration is retained, so a later start reruns the identical burst.
- Stop
  - stop in RUN: next cycle state=ARMED, sq_out=0, tick=0, no done pulse.
  - stop coinciding with the final tick: stop wins, no done.
- start while in RUN is ignored.
- Counter widths
  - tally saturates at all-ones.
  - When burst_reg=0, tally is not compared.

Optional Feature:
FREQ_DIV_CTRL_RELOAD_EN
- Defined:
  - cfg_ready=1 also in RUN.
  - An accepted configuration is held pending and applied on the cycle after the next tick: new period starts with k=0 under the new D, and tally resets to 0.
  - A second handshake before that boundary replaces the pending value.
  - stop or init discards the pending value.
- Undefined: cfg_ready=0 throughout RUN; no pending register exists.

Decomposition:
- Package freq_div_pkg:
  - state enum typedef (IDLE, ARMED, RUN; 2-bit);
  - MIN_DIV=2 constant;
  - default CNT_W/BURST_W constants.
- One sub-module, div_period_cnt:
  - inputs: clk, init, clear, en, div;
  - outputs: registered k and a last flag (k==div-1).
  - Controller FSM, tally and output registers stay in freq_div_ctrl.

Test Plan:
- Reset mid-run: init asserted in RUN with D=4 -> outputs 0 asynchronously, cfg_ready=1, state IDLE.
- Continuous even divisor: cfg D=4, burst=0, start -> sq_out 1,1,0,0 repeating; tick on every 4th cycle; busy stays 1.
- Burst end: D=3, burst=2 -> sq_out pattern 1,0,0,1,0,0; ticks on cycles 3 and 6; done=1 on cycle 7; busy=0; rerun on a new start.
- Clamp and odd divisor: cfg_div=0 then 1 -> both behave as D=2 (sq_out 1,0; tick every 2nd cycle); D=5 -> high 2, low 3.
- Stop priority: start&stop in ARMED -> no RUN; stop on final tick cycle of a burst=1 run -> ARMED, done never pulses.
- Handshake gating: cfg_valid held in RUN -> cfg_ready=0 with macro off. With FREQ_DIV_CTRL_RELOAD_EN on: D 4->2 accepted mid-period, applied after the next tick, tally restarts.

Source files
------------

// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared types and constants for the divided-clock controller.
//   state_t     - controller state encoding (IDLE, ARMED, RUN), 2 bits
//   MIN_DIV     - smallest divisor the controller will run with
//   CNT_W_DEF   - default width of the divisor / period index
//   BURST_W_DEF - default width of the burst length / period tally
package freq_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int BURST_W_DEF = 8;
  localparam int MIN_DIV     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/div_period_cnt.sv
// div_period_cnt: period index counter for the clock divider.
//   clk   in   system clock
//   init  in   asynchronous active-high reset
//   clear in   force k to 0 (takes priority over en)
//   en    in   advance k by one, wrapping to 0 after div-1
//   div   in   current divisor D
//   k     out  registered period index 0..D-1
//   last  out  high when k == D-1 (decoded from registered k and div)
module div_period_cnt
  import freq_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             init,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] k,
  output logic             last
);

  assign last = (k == div - CNT_W'(1));

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      k <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (en) begin
      k <= last ? '0 : k + CNT_W'(1);
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: sequencing controller for the programmable clock divider.
//   clk       in   system clock
//   init      in   asynchronous active-high reset
//   cfg_valid in   configuration offered
//   cfg_ready out  configuration can be accepted
//   cfg_div   in   divisor D (clamped to at least 2)
//   cfg_burst in   periods per burst, 0 = continuous
//   start     in   begin generation (level, honoured in ARMED only)
//   stop      in   abort generation (beats start and the final tick)
//   sq_out    out  divided square wave, high for k < floor(D/2)
//   tick      out  one-cycle pulse on k == D-1
//   busy      out  high while in RUN
//   done      out  one-cycle pulse after the final burst period
// Optional build macro FREQ_DIV_CTRL_RELOAD_EN: accept configuration while
// running; it is applied at the next period boundary and restarts the tally.
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               init,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               sq_out,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     div_reg, div_next, div_clamped;
  logic [BURST_W-1:0]   burst_reg, burst_next;
  logic [BURST_W-1:0]   tally_reg, tally_next, tally_inc;
  logic [CNT_W-1:0]     k, k_next;
  logic                 last, cnt_clear, cnt_en, cfg_hs, final_period;
  logic                 sq_reg, tick_reg, busy_reg, done_reg;
  logic                 sq_next, tick_next, busy_next, done_next;

`ifdef FREQ_DIV_CTRL_RELOAD_EN
  logic                 pend_valid_reg, pend_valid_next;
  logic [CNT_W-1:0]     pend_div_reg, pend_div_next;
  logic [BURST_W-1:0]   pend_burst_reg, pend_burst_next;
  assign cfg_ready = 1'b1;
`else
  assign cfg_ready = (state_reg != RUN);
`endif

  assign cfg_hs      = cfg_valid & cfg_ready;
  assign div_clamped = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;
  assign tally_inc   = (&tally_reg) ? tally_reg : tally_reg + BURST_W'(1);
  // Only meaningful on a tick in RUN; burst_reg == 0 means never ends.
  assign final_period = (burst_reg != '0) && ((tally_reg + BURST_W'(1)) == burst_reg);

  // The index runs only while staying in RUN; any entry to or exit from RUN
  // leaves it at 0, so the first RUN cycle is always k = 0.
  assign cnt_en    = (state_reg == RUN);
  assign cnt_clear = !((state_reg == RUN) && (state_next == RUN));
  // Mirror of the counter's update, needed so outputs can be registered
  // with the value belonging to the cycle that k will name.
  assign k_next    = cnt_clear ? '0 : (last ? '0 : k + CNT_W'(1));

  div_period_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .init  (init),
    .clear (cnt_clear),
    .en    (cnt_en),
    .div   (div_reg),
    .k     (k),
    .last  (last)
  );

  // State and data registers
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_reg <= IDLE;
      div_reg   <= CNT_W'(MIN_DIV);
      burst_reg <= '0;
      tally_reg <= '0;
      sq_reg    <= 1'b0;
      tick_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef FREQ_DIV_CTRL_RELOAD_EN
      pend_valid_reg <= 1'b0;
      pend_div_reg   <= CNT_W'(MIN_DIV);
      pend_burst_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      burst_reg <= burst_next;
      tally_reg <= tally_next;
      sq_reg    <= sq_next;
      tick_reg  <= tick_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef FREQ_DIV_CTRL_RELOAD_EN
      pend_valid_reg <= pend_valid_next;
      pend_div_reg   <= pend_div_next;
      pend_burst_reg <= pend_burst_next;
`endif
    end
  end

  // Next-state and data
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    burst_next = burst_reg;
    tally_next = tally_reg;
    done_next  = 1'b0;
`ifdef FREQ_DIV_CTRL_RELOAD_EN
    pend_valid_next = pend_valid_reg;
    pend_div_next   = pend_div_reg;
    pend_burst_next = pend_burst_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cfg_hs) begin
          div_next   = div_clamped;
          burst_next = cfg_burst;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (cfg_hs) begin
          div_next   = div_clamped;
          burst_next = cfg_burst;
        end
        if (start && !stop) begin
          state_next = RUN;
          tally_next = '0;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort: no done pulse; a pending reload (even one offered this
          // cycle) is discarded.
          state_next = ARMED;
`ifdef FREQ_DIV_CTRL_RELOAD_EN
          pend_valid_next = 1'b0;
`endif
        end else begin
          if (last) begin
            tally_next = tally_inc;
            if (final_period) begin
              state_next = ARMED;
              done_next  = 1'b1;
            end
          end
`ifdef FREQ_DIV_CTRL_RELOAD_EN
          // Apply a previously accepted config at the period boundary. A
          // config accepted in the tick cycle itself waits for the next one.
          if (last && pend_valid_reg) begin
            div_next        = pend_div_reg;
            burst_next      = pend_burst_reg;
            tally_next      = '0;
            pend_valid_next = 1'b0;
          end
          if (cfg_hs) begin
            pend_div_next   = div_clamped;
            pend_burst_next = cfg_burst;
            pend_valid_next = 1'b1;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, registered above
  always_comb begin
    busy_next = (state_next == RUN);
    sq_next   = busy_next && (k_next < (div_next >> 1));
    tick_next = busy_next && (k_next == div_next - CNT_W'(1));
  end

  assign sq_out = sq_reg;
  assign tick   = tick_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed bench for freq_div_ctrl. Each step queues the
// expected {cfg_ready,busy,sq_out,tick,done} for the cycle after the next
// rising edge and checks it 1 time unit after that edge.
module tb_freq_div_ctrl;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_div = 8'd0;
  logic [7:0] cfg_burst = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sq_out, tick, busy, done;

`ifdef FREQ_DIV_CTRL_RELOAD_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  freq_div_ctrl #(.CNT_W(8), .BURST_W(8)) dut (
    .clk       (clk),
    .init      (init),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .sq_out    (sq_out),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ev(logic r, logic b, logic s, logic t, logic d);
    return {r, b, s, t, d};
  endfunction

  task automatic push_exp(string tag, logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t       e;
    logic [4:0] obs;
    e   = sb.pop_front();
    obs = {cfg_ready, busy, sq_out, tick, done};
    vectors++;
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (ready,busy,sq,tick,done)", e.tag, obs, e.v);
    end
    if (obs === e.v) $display("vec %0d %s: %b", vectors, e.tag, obs);
  endtask

  task automatic step(string tag, logic [4:0] v);
    push_exp(tag, v);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic check_now(string tag, logic [4:0] v);
    push_exp(tag, v);
    compare_head();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", ev(1, 0, 0, 0, 0));
    init = 1'b0;

    // Continuous D=4; without reload, a config held in RUN must be refused
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_burst = 8'd0;
    step("cfg_d4", ev(1, 0, 0, 0, 0));
    cfg_valid = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step($sformatf("d4_i%0d", i), ev(RR, 1, (i % 4) < 2, (i % 4) == 3, 0));
      start = 1'b0;
`ifndef FREQ_DIV_CTRL_RELOAD_EN
      cfg_valid = 1'b1; cfg_div = 8'd2;
`endif
    end
    cfg_valid = 1'b0;
    step("d4_i12", ev(RR, 1, 1, 0, 0));

    // Asynchronous reset mid-run, then start in IDLE is ignored
    #2 init = 1'b1;
    #1 check_now("init_async", ev(1, 0, 0, 0, 0));
    @(posedge clk);
    #1 init = 1'b0; start = 1'b1;
    step("idle_start", ev(1, 0, 0, 0, 0));
    start = 1'b0;

    // Burst D=3 x2, then identical rerun
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_burst = 8'd2;
    step("cfg_d3b2", ev(1, 0, 0, 0, 0));
    cfg_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step($sformatf("b_r%0d_i%0d", r, i), ev(RR, 1, (i % 3) == 0, (i % 3) == 2, 0));
        start = 1'b0;
      end
      step($sformatf("b_r%0d_done", r), ev(1, 0, 0, 0, 1));
      step($sformatf("b_r%0d_after", r), ev(1, 0, 0, 0, 0));
    end

    // Divisor 0 and 1 clamp to 2
    for (int d = 0; d < 2; d++) begin
      cfg_valid = 1'b1; cfg_div = 8'(d); cfg_burst = 8'd0;
      step($sformatf("cfg_clamp%0d", d), ev(1, 0, 0, 0, 0));
      cfg_valid = 1'b0; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step($sformatf("clamp%0d_i%0d", d, i), ev(RR, 1, (i % 2) == 0, (i % 2) == 1, 0));
        start = 1'b0;
      end
      stop = 1'b1;
      step($sformatf("clamp%0d_stop", d), ev(1, 0, 0, 0, 0));
      stop = 1'b0;
    end

    // Odd divisor D=5: high 2, low 3
    cfg_valid = 1'b1; cfg_div = 8'd5; cfg_burst = 8'd0;
    step("cfg_d5", ev(1, 0, 0, 0, 0));
    cfg_valid = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("d5_i%0d", i), ev(RR, 1, (i % 5) < 2, (i % 5) == 4, 0));
      start = 1'b0;
    end
    stop = 1'b1;
    step("d5_stop", ev(1, 0, 0, 0, 0));

    // start & stop together in ARMED: stop wins
    start = 1'b1;
    step("start_stop", ev(1, 0, 0, 0, 0));
    start = 1'b0; stop = 1'b0;

    // Stop on the final tick of a burst=1 run: no done
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_burst = 8'd1;
    step("cfg_d2b1", ev(1, 0, 0, 0, 0));
    cfg_valid = 1'b0; start = 1'b1;
    step("b1_k0", ev(RR, 1, 1, 0, 0));
    start = 1'b0;
    step("b1_k1", ev(RR, 1, 0, 1, 0));
    stop = 1'b1;
    step("b1_stop_final", ev(1, 0, 0, 0, 0));
    stop = 1'b0;
    step("b1_no_done", ev(1, 0, 0, 0, 0));

`ifdef FREQ_DIV_CTRL_RELOAD_EN
    // Reload D4/burst3 -> D2/burst2 mid-period; tally restarts at boundary
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_burst = 8'd3;
    step("rl_cfg", ev(1, 0, 0, 0, 0));
    cfg_valid = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rl_p1_k%0d", i), ev(1, 1, i < 2, i == 3, 0));
      start = 1'b0;
    end
    step("rl_p2_k0", ev(1, 1, 1, 0, 0));
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_burst = 8'd2;
    step("rl_p2_k1", ev(1, 1, 1, 0, 0));
    cfg_valid = 1'b0;
    step("rl_p2_k2", ev(1, 1, 0, 0, 0));
    step("rl_p2_k3", ev(1, 1, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rl_new_i%0d", i), ev(1, 1, (i % 2) == 0, (i % 2) == 1, 0));
    end
    step("rl_done", ev(1, 0, 0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
